// File: rtl/instr_seq_if.sv
// Memory-side handshake bundle for instr_sequencer: instruction fetch and data access.
// master = sequencer, slave = memory system.
interface instr_seq_if;
    logic imem_req;
    logic imem_ready;
    logic dmem_req;
    logic dmem_we;
    logic dmem_ready;

    // Handshakes: a request is held high for as long as the sequencer waits in FETCH or MEM.
    // The access completes in the cycle where ready=1 while req=1. ready seen without req is ignored.
    modport master (
        output imem_req,
        output dmem_req,
        output dmem_we,
        input  imem_ready,
        input  dmem_ready
    );

    modport slave (
        input  imem_req,
        input  dmem_req,
        input  dmem_we,
        output imem_ready,
        output dmem_ready
    );
endinterface

// File: rtl/instr_sequencer.sv
// Multi-cycle RV32I instruction sequencer: FETCH/DECODE/EXEC/MEM/WB with trap and retire counter.
// Optional float-ALU handoff (falu_start/falu_done, FWAIT state) is enabled by `define INSTR_SEQ_FALU_EN.
module instr_sequencer #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic [6:0]       opcode,
    input  logic             branch_taken,
    instr_seq_if.master      bus,
    output logic             ir_we,
    output logic             reg_we,
    output logic             pc_we,
    output logic [1:0]       pc_sel,
    output logic             trap,
    output logic [1:0]       trap_cause,
    output logic             busy,
    output logic [CNT_W-1:0] instret,
`ifdef INSTR_SEQ_FALU_EN
    output logic             falu_start,
    input  logic             falu_done,
`endif
    output logic [2:0]       dbg_state
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_FALU   = 7'b1010011;

    localparam logic [7:0] TMO = 8'(MEM_TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_TRAP   = 3'd6,
        S_FWAIT  = 3'd7
    } state_t;

    state_t     state;
    state_t     retire_next;
    logic [7:0] wait_cnt;
    logic       cls_load;
    logic       cls_store;
    logic       cls_branch;
    logic       cls_jal;
    logic       cls_jalr;
`ifdef INSTR_SEQ_FALU_EN
    logic       cls_falu;
`endif

    function automatic logic op_legal(input logic [6:0] op);
        case (op)
            OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH,
            OP_JAL, OP_JALR, OP_AUIPC, OP_LUI: op_legal = 1'b1;
`ifdef INSTR_SEQ_FALU_EN
            OP_FALU: op_legal = 1'b1;
`endif
            default: op_legal = 1'b0;
        endcase
    endfunction

    // Outputs tied to the registered state.
    assign bus.imem_req = (state == S_FETCH);
    assign bus.dmem_req = (state == S_MEM);
    assign bus.dmem_we  = (state == S_MEM) && cls_store;
    assign trap         = (state == S_TRAP);
    assign busy         = (state != S_IDLE) && (state != S_TRAP);
    assign dbg_state    = state;
    assign retire_next  = run ? S_FETCH : S_IDLE;

`ifdef INSTR_SEQ_FALU_EN
    assign falu_start = (state == S_EXEC) && cls_falu;
`endif

    // Write strobes follow the current state and this cycle's handshake inputs.
    always_comb begin
        ir_we  = 1'b0;
        reg_we = 1'b0;
        pc_we  = 1'b0;
        pc_sel = 2'd0;
        case (state)
            S_FETCH: ir_we = bus.imem_ready;
            S_EXEC: begin
                if (cls_branch) begin
                    pc_we  = 1'b1;
                    pc_sel = branch_taken ? 2'd1 : 2'd0;
                end
            end
            S_MEM: pc_we = cls_store && bus.dmem_ready;
            S_WB: begin
                reg_we = 1'b1;
                pc_we  = 1'b1;
                pc_sel = cls_jal ? 2'd1 : (cls_jalr ? 2'd2 : 2'd0);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            wait_cnt   <= 8'd0;
            instret    <= '0;
            trap_cause <= 2'd0;
            cls_load   <= 1'b0;
            cls_store  <= 1'b0;
            cls_branch <= 1'b0;
            cls_jal    <= 1'b0;
            cls_jalr   <= 1'b0;
`ifdef INSTR_SEQ_FALU_EN
            cls_falu   <= 1'b0;
`endif
        end else begin
            // pc_we is only ever raised on the retiring cycle of an instruction.
            if (pc_we) begin
                instret <= instret + CNT_W'(1);
            end
            case (state)
                S_IDLE: begin
                    if (run) state <= S_FETCH;
                end
                S_FETCH: begin
                    if (bus.imem_ready) begin
                        wait_cnt <= 8'd0;
                        state    <= S_DECODE;
                    end else if (wait_cnt + 8'd1 == TMO) begin
                        trap_cause <= 2'd2;
                        state      <= S_TRAP;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                S_DECODE: begin
                    wait_cnt   <= 8'd0;
                    cls_load   <= (opcode == OP_LOAD);
                    cls_store  <= (opcode == OP_STORE);
                    cls_branch <= (opcode == OP_BRANCH);
                    cls_jal    <= (opcode == OP_JAL);
                    cls_jalr   <= (opcode == OP_JALR);
`ifdef INSTR_SEQ_FALU_EN
                    cls_falu   <= (opcode == OP_FALU);
`endif
                    if (op_legal(opcode)) begin
                        state <= S_EXEC;
                    end else begin
                        trap_cause <= 2'd1;
                        state      <= S_TRAP;
                    end
                end
                S_EXEC: begin
                    if (cls_load || cls_store) state <= S_MEM;
                    else if (cls_branch)       state <= retire_next;
`ifdef INSTR_SEQ_FALU_EN
                    else if (cls_falu)         state <= S_FWAIT;
`endif
                    else                       state <= S_WB;
                end
                S_MEM: begin
                    if (bus.dmem_ready) begin
                        wait_cnt <= 8'd0;
                        state    <= cls_store ? retire_next : S_WB;
                    end else if (wait_cnt + 8'd1 == TMO) begin
                        trap_cause <= 2'd2;
                        state      <= S_TRAP;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                S_WB: state <= retire_next;
`ifdef INSTR_SEQ_FALU_EN
                S_FWAIT: begin
                    if (falu_done) state <= S_WB;
                end
`endif
                S_TRAP: state <= S_TRAP;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: directed plus randomized instruction streams,
// retirement scoreboard, fetch/data timeouts, illegal-opcode trap and reset recovery.
module tb_instr_sequencer;
    localparam int TMO = 4;
    localparam int CW  = 32;
    localparam int W   = 16;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          run = 1'b0;
    logic [6:0]    opcode = 7'd0;
    logic          branch_taken = 1'b0;
    logic          ir_we, reg_we, pc_we, trap, busy;
    logic [1:0]    pc_sel, trap_cause;
    logic [CW-1:0] instret;
    logic [2:0]    dbg_state;
`ifdef INSTR_SEQ_FALU_EN
    logic          falu_start;
    logic          falu_done = 1'b0;
`endif

    instr_seq_if bus ();

    int            checks = 0;
    int            failures = 0;
    logic [W-1:0]  exp_q[$];
    logic [CW-1:0] exp_instret = '0;
    logic [6:0]    op_tab[9];

    instr_sequencer #(.MEM_TIMEOUT(TMO), .CNT_W(CW)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .run(run),
        .opcode(opcode),
        .branch_taken(branch_taken),
        .bus(bus),
        .ir_we(ir_we),
        .reg_we(reg_we),
        .pc_we(pc_we),
        .pc_sel(pc_sel),
        .trap(trap),
        .trap_cause(trap_cause),
        .busy(busy),
        .instret(instret),
`ifdef INSTR_SEQ_FALU_EN
        .falu_start(falu_start),
        .falu_done(falu_done),
`endif
        .dbg_state(dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        run = 1'b0;
        bus.imem_ready = 1'b0;
        bus.dmem_ready = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        exp_instret = '0;
    endtask

    task automatic start_fetch();
        run = 1'b1;
        @(posedge clk); #1;
    endtask

    // Drives one instruction starting in FETCH; iw/dw are wait cycles before imem/dmem ready.
    task automatic run_instr(input logic [6:0] opc, input int iw, input int dw,
                             input logic taken, input logic run_after);
        logic         is_ld, is_st, is_br, exp_reg, seen;
        logic [1:0]   psel;
        logic [W-1:0] ent;
        int           lat;
        is_ld = (opc == OP_LOAD);
        is_st = (opc == OP_STORE);
        is_br = (opc == OP_BRANCH);
        lat = is_br ? 3 : (is_ld ? 5 + dw : (is_st ? 4 + dw : 4));
        lat = lat + iw;
        psel = is_br ? (taken ? 2'd1 : 2'd0) :
               (opc == OP_JAL) ? 2'd1 : (opc == OP_JALR) ? 2'd2 : 2'd0;
        exp_reg = !(is_br || is_st);
        exp_q.push_back({lat[7:0], 5'b0, exp_reg, psel});
        opcode = opc;
        branch_taken = taken;
        seen = 1'b0;
        for (int k = 1; k <= lat + 3 && !seen; k++) begin
            bus.imem_ready = (k == iw + 1);
            bus.dmem_ready = (is_ld || is_st) && (k == iw + 4 + dw);
            run = (k == lat) ? run_after : 1'b1;
            @(negedge clk);
            check_eq("imem_req", 32'(bus.imem_req), 32'(k <= iw + 1));
            check_eq("dmem_req", 32'(bus.dmem_req),
                     32'((is_ld || is_st) && k >= iw + 4 && k <= iw + 4 + dw));
            check_eq("dmem_we", 32'(bus.dmem_we),
                     32'(is_st && k >= iw + 4 && k <= iw + 4 + dw));
            check_eq("reg_we", 32'(reg_we), 32'(exp_reg && k == lat));
            if (k == iw + 1) check_eq("ir_we", 32'(ir_we), 32'd1);
            if (pc_we) begin
                seen = 1'b1;
                if (exp_q.size() == 0) begin
                    check_eq("spurious_retire", 32'd1, 32'd0);
                end else begin
                    ent = exp_q.pop_front();
                    check_eq("retire", 32'({k[7:0], 5'b0, reg_we, pc_sel}), 32'(ent));
                end
            end
            @(posedge clk); #1;
        end
        bus.imem_ready = 1'b0;
        bus.dmem_ready = 1'b0;
        if (!seen) begin
            check_eq("retire_timeout", 32'd0, 32'd1);
            if (exp_q.size() != 0) ent = exp_q.pop_front();
        end else begin
            exp_instret = exp_instret + 1;
            check_eq("instret", instret, exp_instret);
        end
    endtask

    task automatic check_illegal(input logic [6:0] opc);
        opcode = opc;
        bus.imem_ready = 1'b1;
        @(posedge clk); #1;
        bus.imem_ready = 1'b0;
        @(posedge clk); #1;
        check_eq("ill_trap", 32'(trap), 32'd1);
        check_eq("ill_cause", 32'(trap_cause), 32'd1);
        check_eq("ill_busy", 32'(busy), 32'd0);
        for (int i = 0; i < 20; i++) begin
            bus.imem_ready = 1'($urandom_range(0, 1));
            bus.dmem_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            check_eq("trap_quiet", 32'({bus.imem_req, bus.dmem_req, pc_we, reg_we}), 32'd0);
            @(posedge clk); #1;
        end
        check_eq("ill_instret", instret, exp_instret);
        do_reset();
        check_eq("ill_reset_trap", 32'({trap, trap_cause}), 32'd0);
        check_eq("ill_reset_instret", instret, 32'd0);
    endtask

    initial begin
        op_tab = '{OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_AUIPC, OP_LUI};
        bus.imem_ready = 1'b0;
        bus.dmem_ready = 1'b0;

        do_reset();
        check_eq("rst_state", 32'({bus.imem_req, bus.dmem_req, bus.dmem_we, trap, busy}), 32'd0);
        check_eq("rst_strobes", 32'({ir_we, reg_we, pc_we, pc_sel}), 32'd0);
        check_eq("rst_cause", 32'(trap_cause), 32'd0);
        check_eq("rst_instret", instret, 32'd0);

        start_fetch();
        check_eq("first_fetch", 32'(bus.imem_req), 32'd1);
        check_eq("first_busy", 32'(busy), 32'd1);
        repeat (3) run_instr(OP_R, 0, 0, 1'b0, 1'b1);
        run_instr(OP_LOAD, 0, 3, 1'b0, 1'b1);
        run_instr(OP_BRANCH, 0, 0, 1'b1, 1'b1);
        run_instr(OP_BRANCH, 0, 0, 1'b0, 1'b1);
        run_instr(OP_STORE, 0, 0, 1'b0, 1'b1);
        run_instr(OP_LUI, 1, 0, 1'b0, 1'b1);
        run_instr(OP_AUIPC, 0, 0, 1'b0, 1'b1);
        run_instr(OP_JAL, 0, 0, 1'b0, 1'b1);
        run_instr(OP_IMM, 2, 0, 1'b0, 1'b1);
        run_instr(OP_JALR, 0, 0, 1'b0, 1'b0);
        check_eq("idle_busy", 32'(busy), 32'd0);
        check_eq("idle_imem_req", 32'(bus.imem_req), 32'd0);
        start_fetch();
        check_eq("rerun_fetch", 32'(bus.imem_req), 32'd1);

        for (int i = 0; i < 12; i++) begin
            run_instr(op_tab[$urandom_range(0, 8)], $urandom_range(0, 2), $urandom_range(0, 2),
                      1'($urandom_range(0, 1)), 1'b1);
        end

        // fetch timeout: TMO cycles without imem_ready
        bus.imem_ready = 1'b0;
        repeat (TMO - 1) begin
            @(posedge clk); #1;
        end
        check_eq("fto_pre_trap", 32'(trap), 32'd0);
        check_eq("fto_pre_req", 32'(bus.imem_req), 32'd1);
        @(posedge clk); #1;
        check_eq("fto_trap", 32'(trap), 32'd1);
        check_eq("fto_cause", 32'(trap_cause), 32'd2);
        check_eq("fto_instret", instret, exp_instret);
        do_reset();
        start_fetch();
        run_instr(OP_R, TMO - 1, 0, 1'b0, 1'b1);
        check_eq("fto_edge_notrap", 32'(trap), 32'd0);

        // data timeout on a store that is never acknowledged
        opcode = OP_STORE;
        bus.imem_ready = 1'b1;
        @(posedge clk); #1;
        bus.imem_ready = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        check_eq("mto_req", 32'({bus.dmem_req, bus.dmem_we}), 32'd3);
        repeat (TMO - 1) begin
            @(posedge clk); #1;
        end
        check_eq("mto_pre_trap", 32'(trap), 32'd0);
        @(posedge clk); #1;
        check_eq("mto_trap", 32'({trap, trap_cause}), 32'b110);
        check_eq("mto_instret", instret, exp_instret);
        do_reset();

        start_fetch();
        check_illegal(7'b1111111);
`ifndef INSTR_SEQ_FALU_EN
        start_fetch();
        check_illegal(7'b1010011);
`else
        begin
            int starts;
            logic seen;
            starts = 0;
            seen = 1'b0;
            start_fetch();
            opcode = 7'b1010011;
            bus.imem_ready = 1'b1;
            @(posedge clk); #1;
            bus.imem_ready = 1'b0;
            @(posedge clk); #1;
            for (int k = 0; k < 12 && !seen; k++) begin
                falu_done = (k == 6);
                @(negedge clk);
                if (falu_start) starts++;
                if (pc_we) begin
                    seen = 1'b1;
                    check_eq("falu_wb_cycle", 32'(k), 32'd7);
                    check_eq("falu_wb_reg_we", 32'(reg_we), 32'd1);
                end
                @(posedge clk); #1;
            end
            falu_done = 1'b0;
            check_eq("falu_seen", 32'(seen), 32'd1);
            check_eq("falu_start_pulses", 32'(starts), 32'd1);
            exp_instret = exp_instret + 1;
            check_eq("falu_instret", instret, exp_instret);
        end
`endif

        check_eq("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
